// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK bus levels,
// default address and the majority-vote helper used by the glitch filter.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        READ_ACK  = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
    localparam logic [6:0] DEFAULT_ADDR = 7'h42;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line: synchronizer chain, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), and edge detection on the cleaned level.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   clean_s;
    logic                   prev_r;

    // Synchronizer chain; reset value matches an idle (high) bus
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], line_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;

    // Majority of the last three samples rejects single-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_r <= 2'b11;
            filt_r <= 1'b1;
        end else begin
            hist_r <= {hist_r[0], sync_r[SYNC_STAGES-1]};
            filt_r <= majority3({hist_r, sync_r[SYNC_STAGES-1]});
        end
    end

    assign clean_s = filt_r;
`else
    assign clean_s = sync_r[SYNC_STAGES-1];
`endif

    // Previous-cycle copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= clean_s;
        end
    end

    assign level = clean_s;
    assign rise  = clean_s & ~prev_r;
    assign fall  = ~clean_s & prev_r;

endmodule

// File: rtl/i2c_target.sv
// I2C target (7-bit address) with byte-wide write/read handshakes.
// Optional SCL/SDA glitch filter enabled by I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enabled,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_s, stop_s;

    i2c_state_e state_r, state_n;
    logic [2:0] bit_cnt_r, cnt_n;
    logic [7:0] shift_r, shift_n;
    logic [7:0] rx_data_r, rx_data_n;
    logic       drive_r, drive_n;
    logic       rw_r, rw_n;
    logic       sent_r, sent_n;
    logic       busy_r, busy_n;
    logic       rx_valid_r, rx_valid_n;
    logic       tx_req_r, tx_req_n;
    logic       sda_oe_r;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .line_in(scl_in),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .line_in(sda_in),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    assign start_s = sda_fall & scl_lvl;
    assign stop_s  = sda_rise & scl_lvl;

    // Next-state logic; bus conditions override any SCL-driven activity
    always_comb begin
        state_n    = state_r;
        cnt_n      = bit_cnt_r;
        shift_n    = shift_r;
        drive_n    = drive_r;
        rw_n       = rw_r;
        sent_n     = sent_r;
        busy_n     = busy_r;
        rx_data_n  = rx_data_r;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        if (stop_s) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            drive_n = 1'b0;
            sent_n  = 1'b0;
            busy_n  = 1'b0;
        end else if (start_s) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
            drive_n = 1'b0;
            sent_n  = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state_r)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift_r[6:0], sda_lvl};
                        cnt_n   = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            rw_n    = sda_lvl;
                            state_n = (shift_r[6:0] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
                        end else begin
                            rw_n = rw_r;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                // drive_r doubles as the phase flag: low until the ACK is put on the bus
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_r) begin
                            drive_n = 1'b1;
                            if (rw_r) begin
                                shift_n  = tx_data;
                                tx_req_n = 1'b1;
                            end else begin
                                shift_n = shift_r;
                            end
                        end else if (rw_r) begin
                            drive_n = ~shift_r[7];
                            shift_n = {shift_r[6:0], 1'b0};
                            cnt_n   = 3'd0;
                            sent_n  = 1'b0;
                            state_n = READ;
                        end else begin
                            drive_n = 1'b0;
                            cnt_n   = 3'd0;
                            state_n = WRITE;
                        end
                    end else begin
                        drive_n = drive_r;
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_n = {shift_r[6:0], sda_lvl};
                        cnt_n   = bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            rx_data_n  = {shift_r[6:0], sda_lvl};
                            rx_valid_n = 1'b1;
                            state_n    = WRITE_ACK;
                        end else begin
                            rx_data_n = rx_data_r;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!drive_r) begin
                            drive_n = 1'b1;
                        end else begin
                            drive_n = 1'b0;
                            state_n = WRITE;
                        end
                    end else begin
                        drive_n = drive_r;
                    end
                end
                // shift_r[7] is always the next bit to present on a falling edge
                READ: begin
                    if (scl_rise) begin
                        cnt_n  = bit_cnt_r + 3'd1;
                        sent_n = (bit_cnt_r == 3'd7) ? 1'b1 : sent_r;
                    end else if (scl_fall) begin
                        if (sent_r) begin
                            drive_n = 1'b0;
                            sent_n  = 1'b0;
                            state_n = READ_ACK;
                        end else begin
                            drive_n = ~shift_r[7];
                            shift_n = {shift_r[6:0], 1'b0};
                        end
                    end else begin
                        drive_n = drive_r;
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            state_n = WAIT_STOP;
                        end else begin
                            shift_n  = tx_data;
                            tx_req_n = 1'b1;
                            sent_n   = 1'b0;
                            state_n  = READ;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_n = state_r;
                end
                default: begin
                    state_n = IDLE;
                    drive_n = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; disabled holds state with SDA released
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            drive_r    <= 1'b0;
            rw_r       <= 1'b0;
            sent_r     <= 1'b0;
            busy_r     <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
        end else if (enabled) begin
            state_r    <= state_n;
            bit_cnt_r  <= cnt_n;
            shift_r    <= shift_n;
            drive_r    <= drive_n;
            rw_r       <= rw_n;
            sent_r     <= sent_n;
            busy_r     <= busy_n;
            rx_data_r  <= rx_data_n;
            rx_valid_r <= rx_valid_n;
            tx_req_r   <= tx_req_n;
            sda_oe_r   <= drive_n;
        end else begin
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
        end
    end

    assign sda_oe   = sda_oe_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_req   = tx_req_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: table of write transactions plus
// directed read, repeated-START, mid-read reset and glitch sequences.
module tb_i2c_target;
    import i2c_pkg::*;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_aack;
        logic       exp_dack;
        logic [7:0] exp_rx;
        int         exp_nrx;
        logic       exp_oe;
    } vec_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       enabled  = 1'b1;
    logic       scl_ctrl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data, tx_data;
    logic [7:0] tx_list [8];
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         oe_cnt = 0;
    int         total  = 0;
    int         bad    = 0;
    vec_t       vecs [6];

    always #5 clk = ~clk;

    assign sda_bus = sda_ctrl & ~sda_oe;
    assign tx_data = tx_list[tx_cnt[2:0]];

    i2c_target dut (
        .clk     (clk),
        .reset   (reset),
        .enabled (enabled),
        .scl_in  (scl_ctrl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    // Pulse counters for the strobes and SDA-drive activity
    always @(posedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req)   tx_cnt <= tx_cnt + 1;
        if (sda_oe)   oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_ctrl = 1'b1; scl_ctrl = 1'b1; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic rstart_cond();
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        sda_ctrl = 1'b0; wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic stop_cond();
        sda_ctrl = 1'b0; wait_q();
        scl_ctrl = 1'b1; wait_q();
        sda_ctrl = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_ctrl = b; wait_q();
        scl_ctrl = 1'b1; wait_q(); wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        b = sda_bus; wait_q();
        scl_ctrl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, oe0, tx0;

        tx_list[0] = 8'h3C; tx_list[1] = 8'hC3; tx_list[2] = 8'h96; tx_list[3] = 8'h0F;
        tx_list[4] = 8'h00; tx_list[5] = 8'h00; tx_list[6] = 8'h00; tx_list[7] = 8'h00;

        vecs[0] = '{7'h42, 8'hA5, 1'b0, 1'b0, 8'hA5, 1, 1'b1};
        vecs[1] = '{7'h42, 8'h00, 1'b0, 1'b0, 8'h00, 1, 1'b1};
        vecs[2] = '{7'h42, 8'hFF, 1'b0, 1'b0, 8'hFF, 1, 1'b1};
        vecs[3] = '{7'h43, 8'h5A, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
        vecs[4] = '{7'h42, 8'h81, 1'b0, 1'b0, 8'h81, 1, 1'b1};
        vecs[5] = '{7'h02, 8'h77, 1'b1, 1'b1, 8'h81, 0, 1'b0};

        // reset state
        repeat (4) @(negedge clk);
        chk("reset_sda_oe", 32'(sda_oe), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_state", 32'(dut.state_r), 32'(IDLE));
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_rx_valid", 32'(rx_valid), 32'd0);
        chk("idle_tx_req", 32'(tx_req), 32'd0);

        // table of write transactions
        for (int i = 0; i < 6; i++) begin
            rx0 = rx_cnt;
            oe0 = oe_cnt;
            start_cond();
            chk($sformatf("busy_start[%0d]", i), 32'(busy), 32'd1);
            send_byte({vecs[i].addr, 1'b0}, ack);
            chk($sformatf("addr_ack[%0d]", i), 32'(ack), 32'(vecs[i].exp_aack));
            send_byte(vecs[i].data, ack);
            chk($sformatf("data_ack[%0d]", i), 32'(ack), 32'(vecs[i].exp_dack));
            stop_cond();
            chk($sformatf("rx_data[%0d]", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            chk($sformatf("rx_pulses[%0d]", i), 32'(rx_cnt - rx0), 32'(vecs[i].exp_nrx));
            chk($sformatf("oe_seen[%0d]", i), 32'(oe_cnt != oe0), 32'(vecs[i].exp_oe));
            chk($sformatf("busy_stop[%0d]", i), 32'(busy), 32'd0);
        end

        // read two bytes: ACK then NACK
        tx0 = tx_cnt;
        start_cond();
        send_byte(8'h85, ack);
        chk("rd_addr_ack", 32'(ack), 32'(ACK));
        recv_byte(d, 1'b0);
        chk("rd_byte0", 32'(d), 32'h3C);
        recv_byte(d, 1'b1);
        chk("rd_byte1", 32'(d), 32'hC3);
        chk("rd_tx_req_pulses", 32'(tx_cnt - tx0), 32'd2);
        chk("rd_wait_stop", 32'(dut.state_r), 32'(WAIT_STOP));
        chk("rd_busy", 32'(busy), 32'd1);
        stop_cond();
        chk("rd_busy_stop", 32'(busy), 32'd0);

        // write a byte, repeated START, then read one byte
        start_cond();
        send_byte(8'h84, ack);
        chk("rs_waddr_ack", 32'(ack), 32'd0);
        send_byte(8'h11, ack);
        chk("rs_wdata_ack", 32'(ack), 32'd0);
        chk("rs_rx_data", 32'(rx_data), 32'h11);
        rstart_cond();
        chk("rs_state_addr", 32'(dut.state_r), 32'(ADDR));
        send_byte(8'h85, ack);
        chk("rs_raddr_ack", 32'(ack), 32'd0);
        recv_byte(d, 1'b1);
        chk("rs_rd_byte", 32'(d), 32'h96);
        stop_cond();

        // reset asserted during the 4th bit of a read of 0x0F
        start_cond();
        send_byte(8'h85, ack);
        chk("rst_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) read_bit(ack);
        sda_ctrl = 1'b1; wait_q();
        scl_ctrl = 1'b1; wait_q();
        chk("rst_pre_oe", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_oe_released", 32'(sda_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        scl_ctrl = 1'b0; wait_q();
        stop_cond();
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'h84, ack);
        chk("post_rst_addr_ack", 32'(ack), 32'd0);
        send_byte(8'h3E, ack);
        chk("post_rst_data_ack", 32'(ack), 32'd0);
        stop_cond();
        chk("post_rst_rx_data", 32'(rx_data), 32'h3E);
        chk("post_rst_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // single-clock SCL glitch between bits 4 and 5 of a written byte
        d = 8'hC6;
        start_cond();
        send_byte(8'h84, ack);
        chk("gl_addr_ack", 32'(ack), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            write_bit(d[i]);
            if (i == 4) begin
                chk("gl_cnt_before", 32'(dut.bit_cnt_r), 32'd4);
                @(negedge clk); scl_ctrl = 1'b1;
                @(negedge clk); scl_ctrl = 1'b0;
                wait_q(); wait_q();
                chk("gl_cnt_after", 32'(dut.bit_cnt_r), 32'd4);
            end
        end
        read_bit(ack);
        chk("gl_data_ack", 32'(ack), 32'd0);
        stop_cond();
        chk("gl_rx_data", 32'(rx_data), 32'hC6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h42: 7-bit address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on scl_in/sda_in; legal range 2..3.
REQ-003 clk  input  1  system clock; at least 8x SCL rate.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 enabled  input  1  when 0, state frozen, sda_oe forced 0.
REQ-006 scl_in  input  1  raw bus SCL, asynchronous.
REQ-007 sda_in  input  1  raw bus SDA, asynchronous.
REQ-008 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-009 rx_data  output  8  last byte written by the controller.
REQ-010 rx_valid  output  1  one-cycle strobe; rx_data new.
REQ-011 tx_data  input  8  byte to return on a read.
REQ-012 tx_req  output  1  one-cycle strobe; tx_data latched, next byte may be presented.
REQ-013 busy  output  1  high from START until STOP.

Function
REQ-014 scl_in/sda_in SHALL pass through SYNC_STAGES flops; edges are detected on synchronized values (scl_s, sda_s) against their previous-cycle copies.
REQ-015 START = sda_s falling while scl_s high; STOP = sda_s rising while scl_s high; both SHALL be detected in any state, including mid-byte.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-017 START (including repeated START) SHALL move to ADDR, clear bit counter, release sda_oe, assert busy.
REQ-018 STOP SHALL move to IDLE, release sda_oe, deassert busy; STOP wins over any same-cycle SCL edge.
REQ-019 Data bits SHALL be sampled on scl_s rising edge, MSB first, 3-bit counter, wrap after 8.
REQ-020 ADDR: after 8th bit, if bits[7:1]==TARGET_ADDR go to ADDR_ACK, else WAIT_STOP (no ACK, sda_oe stays 0).
REQ-021 ACK drive: sda_oe SHALL rise on the scl_s falling edge after the 8th rising edge and fall on the next scl_s falling edge.
REQ-022 ADDR_ACK with R/W=0 -> WRITE; with R/W=1 -> READ, tx_data latched into shift register and tx_req pulsed on the same cycle sda_oe rises.
REQ-023 WRITE: on 8th rising edge rx_data updates and rx_valid pulses the same cycle; -> WRITE_ACK (ACK always given) -> WRITE.
REQ-024 READ: sda_oe = ~shift[7], updated on each scl_s falling edge; after 8 bits release SDA -> READ_ACK.
REQ-025 READ_ACK: sample sda_s at scl_s rising; 0 (ACK) -> latch tx_data, pulse tx_req, -> READ; 1 (NACK) -> WAIT_STOP.
REQ-026 WAIT_STOP SHALL ignore all SCL activity and leave only via START or STOP.
REQ-027 rx_valid and tx_req SHALL never be high more than one consecutive cycle.

Reset
REQ-028 reset low at a clk edge: state IDLE, counter 0, sda_oe 0, rx_data 8'h00, rx_valid 0, tx_req 0, busy 0, synchronizer flops 1 (bus idle).
REQ-029 Reset mid-transfer SHALL release SDA in the next cycle; the target SHALL then wait for a fresh START.

Configuration
REQ-030 Macro I2C_TARGET_GLITCH_FILTER_EN defined: 3-sample majority filter after the synchronizer on each line, adding 2 cycles of latency; pulses of 1 clk width are rejected.
REQ-031 Macro undefined: no filter; synchronizer output used directly.

Structure
REQ-032 Shared package i2c_pkg SHALL hold the state enum, ACK/NACK constants, and the default address.
REQ-033 Sub-module i2c_line_sync (synchronizer plus optional filter plus edge detect) SHALL be instantiated once per line.

Verification
REQ-034 Write to 0x42 with data 0xA5 then STOP -> ACK on address and data; rx_data=0xA5; exactly one rx_valid; busy low after STOP.
REQ-035 Address 0x43 -> no ACK (sda_oe never 1); data bytes ignored; no rx_valid until the next START.
REQ-036 Read from 0x42, tx_data=0x3C then 0xC3, controller ACK then NACK -> bus shows 0x3C, 0xC3; two tx_req pulses; state WAIT_STOP.
REQ-037 Repeated START after a write byte, then a read -> re-enters ADDR; read completes correctly.
REQ-038 reset pulled low during the 4th bit of a read -> sda_oe 0 the next cycle; a later full transaction succeeds.
REQ-039 With I2C_TARGET_GLITCH_FILTER_EN, a 1-clk SCL glitch during WRITE -> bit counter unchanged and received byte correct.
